// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mips_mem_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int LAT_W      = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    // The starvation counter must hold MAX_WAIT and is never narrower than 3 bits.
    function automatic int wait_width(input int max_wait);
        int w;
        w = $clog2(max_wait + 1);
        return (w < 3) ? 3 : w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory macro signals around the arbiter.
interface mem_port_arbiter_if
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [3:0]        dm_be;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [31:0]       dm_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic              busy;

    // slave: the arbiter itself; master: requesters plus the memory macro.
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_addr, mem_we, mem_be, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_addr, mem_we, mem_be, mem_wdata, busy
    );

endinterface

// File: rtl/mem_arb_sel.sv
// Grant selection between fetch and data paths with a bounded-starvation counter for fetch.
module mem_arb_sel
    import mips_mem_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic grant_en,
    input  logic if_req,
    input  logic dm_req,
    output logic if_gnt,
    output logic dm_gnt
);

    localparam int WAIT_W = wait_width(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;
    logic              if_starved;

    assign if_starved = (wait_cnt == WAIT_W'(MAX_WAIT));

    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (grant_en) begin
            if (dm_req && !(if_req && if_starved)) begin
                dm_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    // Counts data grants that bypassed a waiting fetch; any gap in if_req resets the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            wait_cnt <= '0;
        end else if (dm_gnt && !if_starved) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between instruction fetch and data access, one access at a time.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int LAT      = 1,
    parameter int MAX_WAIT = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    state_e            state;
    state_e            state_nxt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [LAT_W-1:0]  lat_cnt_nxt;

    owner_e            owner_r;
    logic              we_r;
    logic [3:0]        be_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;

    logic              if_rvalid_r;
    logic              dm_rvalid_r;
    logic [31:0]       if_rdata_r;
    logic [31:0]       dm_rdata_r;

    logic              grant_en;
    logic              if_gnt;
    logic              dm_gnt;
    logic              last_cycle;

    // Grants only in IDLE, and never while reset is held so every output reads 0 in reset.
    assign grant_en   = (state == IDLE) && rst;
    assign last_cycle = (state == ACCESS) && (lat_cnt == LAT_W'(LAT - 1));

    mem_arb_sel #(
        .MAX_WAIT (MAX_WAIT)
    ) u_sel (
        .clk      (clk),
        .rst      (rst),
        .grant_en (grant_en),
        .if_req   (bus.if_req),
        .dm_req   (bus.dm_req),
        .if_gnt   (if_gnt),
        .dm_gnt   (dm_gnt)
    );

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        case (state)
            IDLE: begin
                if (if_gnt || dm_gnt) begin
                    state_nxt   = ACCESS;
                    lat_cnt_nxt = '0;
                end
            end
            ACCESS: begin
                if (last_cycle) begin
                    state_nxt   = IDLE;
                    lat_cnt_nxt = '0;
                end else begin
                    lat_cnt_nxt = lat_cnt + LAT_W'(1);
                end
            end
            default: begin
                state_nxt   = IDLE;
                lat_cnt_nxt = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
        end
    end

    // Request fields are frozen at grant; later changes on the request side are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_r     <= OWN_IF;
            we_r        <= 1'b0;
            be_r        <= 4'b0000;
            addr_r      <= '0;
            wdata_r     <= '0;
            if_rvalid_r <= 1'b0;
            dm_rvalid_r <= 1'b0;
            if_rdata_r  <= '0;
            dm_rdata_r  <= '0;
        end else begin
            if_rvalid_r <= 1'b0;
            dm_rvalid_r <= 1'b0;

            if (if_gnt) begin
                owner_r <= OWN_IF;
                we_r    <= 1'b0;
                be_r    <= 4'b0000;
                addr_r  <= bus.if_addr;
                wdata_r <= '0;
            end else if (dm_gnt) begin
                owner_r <= OWN_DM;
                we_r    <= bus.dm_we;
                be_r    <= bus.dm_we ? bus.dm_be : 4'b0000;
                addr_r  <= bus.dm_addr;
                wdata_r <= bus.dm_wdata;
            end

            // Writes are acknowledged through dm_rvalid but leave dm_rdata untouched.
            if (last_cycle) begin
                if (owner_r == OWN_IF) begin
                    if_rvalid_r <= 1'b1;
                    if_rdata_r  <= bus.mem_rdata;
                end else begin
                    dm_rvalid_r <= 1'b1;
                    if (!we_r) begin
                        dm_rdata_r <= bus.mem_rdata;
                    end
                end
            end
        end
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.dm_gnt    = dm_gnt;
    assign bus.if_rvalid = if_rvalid_r;
    assign bus.dm_rvalid = dm_rvalid_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.dm_rdata  = dm_rdata_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_be    = be_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.mem_we    = (state == ACCESS) && (lat_cnt == '0) && (owner_r == OWN_DM) && we_r;
    assign bus.busy      = (state == ACCESS);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of the memory port arbiter at read latencies 1 and 3.
module tb_mem_port_arbiter;

    localparam int AW    = 10;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int MAXW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] mem_a     [1024];
    logic [31:0] mem_b     [1024];
    logic [31:0] model_mem [1024];

    mem_port_arbiter_if #(.ADDR_W(AW)) a ();
    mem_port_arbiter_if #(.ADDR_W(AW)) b ();

    mem_port_arbiter #(.ADDR_W(AW), .LAT(LAT_A), .MAX_WAIT(MAXW)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a)
    );

    mem_port_arbiter #(.ADDR_W(AW), .LAT(LAT_B), .MAX_WAIT(MAXW)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    // Memory macro stand-ins: combinational read, byte-masked write on the clock edge.
    assign a.mem_rdata = mem_a[a.mem_addr];
    assign b.mem_rdata = mem_b[b.mem_addr];

    always @(posedge clk) begin
        if (a.mem_we) mem_a[a.mem_addr] <= merge(mem_a[a.mem_addr], a.mem_wdata, a.mem_be);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " if_gnt"},    64'(a.if_gnt),    64'h0);
        check({tag, " dm_gnt"},    64'(a.dm_gnt),    64'h0);
        check({tag, " if_rvalid"}, 64'(a.if_rvalid), 64'h0);
        check({tag, " dm_rvalid"}, 64'(a.dm_rvalid), 64'h0);
        check({tag, " if_rdata"},  64'(a.if_rdata),  64'h0);
        check({tag, " dm_rdata"},  64'(a.dm_rdata),  64'h0);
        check({tag, " mem_addr"},  64'(a.mem_addr),  64'h0);
        check({tag, " mem_we"},    64'(a.mem_we),    64'h0);
        check({tag, " mem_be"},    64'(a.mem_be),    64'h0);
        check({tag, " mem_wdata"}, 64'(a.mem_wdata), 64'h0);
        check({tag, " busy"},      64'(a.busy),      64'h0);
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] exp_if;
        logic [31:0] exp_dm;
        logic [31:0] pend_data;
        logic [31:0] pend_wdata;
        logic [9:0]  pend_addr;
        logic [3:0]  pend_be;
        logic [9:0]  pat;
        bit          pend_v, pend_dm, pend_wr;
        bit          idle_m, e_if, e_dm, e_ifv, e_dmv, g_if, g_dm;
        int          pend_due, busy_left, wait_m, ng;

        for (int i = 0; i < 1024; i++) begin
            v            = $urandom;
            mem_a[i]     = v;
            model_mem[i] = v;
            mem_b[i]     = 32'hB000_0000 | 32'(i);
        end
        mem_a[4]     = 32'h2008_0005;
        model_mem[4] = 32'h2008_0005;

        a.if_req = 1'b1; a.if_addr = '0; a.dm_req = 1'b1; a.dm_we = 1'b0;
        a.dm_be = 4'h0; a.dm_addr = '0; a.dm_wdata = '0;
        b.if_req = 1'b0; b.if_addr = '0; b.dm_req = 1'b0; b.dm_we = 1'b0;
        b.dm_be = 4'h0; b.dm_addr = '0; b.dm_wdata = '0;

        // Reset with both requests raised: nothing may be granted.
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        a.if_req = 1'b0; a.dm_req = 1'b0;
        rst = 1'b1;

        // Fetch only, LAT = 1.
        a.if_req = 1'b1; a.if_addr = 10'h004;
        sample();
        check("if T gnt", 64'(a.if_gnt), 64'h1);
        check("if T dm_gnt", 64'(a.dm_gnt), 64'h0);
        check("if T busy", 64'(a.busy), 64'h0);
        advance();
        a.if_req = 1'b0; a.if_addr = 10'h3FF;
        sample();
        check("if T+1 mem_addr", 64'(a.mem_addr), 64'h004);
        check("if T+1 busy", 64'(a.busy), 64'h1);
        check("if T+1 rvalid", 64'(a.if_rvalid), 64'h0);
        check("if T+1 mem_we", 64'(a.mem_we), 64'h0);
        check("if T+1 mem_be", 64'(a.mem_be), 64'h0);
        advance();
        sample();
        check("if T+2 rvalid", 64'(a.if_rvalid), 64'h1);
        check("if T+2 rdata", 64'(a.if_rdata), 64'h2008_0005);
        check("if T+2 busy", 64'(a.busy), 64'h0);
        check("if T+2 dm_rvalid", 64'(a.dm_rvalid), 64'h0);
        advance();
        sample();
        check("if T+3 rvalid pulse", 64'(a.if_rvalid), 64'h0);

        // Data write with partial byte enables.
        advance();
        a.dm_req = 1'b1; a.dm_we = 1'b1; a.dm_be = 4'b0011;
        a.dm_addr = 10'h010; a.dm_wdata = 32'hDEAD_BEEF;
        sample();
        check("wr T gnt", 64'(a.dm_gnt), 64'h1);
        check("wr T mem_we", 64'(a.mem_we), 64'h0);
        advance();
        a.dm_req = 1'b0; a.dm_be = 4'hF; a.dm_wdata = 32'h0; a.dm_addr = 10'h000;
        sample();
        check("wr T+1 mem_we", 64'(a.mem_we), 64'h1);
        check("wr T+1 mem_be", 64'(a.mem_be), 64'h3);
        check("wr T+1 mem_wdata", 64'(a.mem_wdata), 64'hDEAD_BEEF);
        check("wr T+1 mem_addr", 64'(a.mem_addr), 64'h010);
        advance();
        sample();
        check("wr T+2 mem_we", 64'(a.mem_we), 64'h0);
        check("wr T+2 dm_rvalid", 64'(a.dm_rvalid), 64'h1);
        check("wr T+2 dm_rdata", 64'(a.dm_rdata), 64'h0);
        check("wr mem word", 64'(mem_a[10'h010]), 64'({model_mem[10'h010][31:16], 16'hBEEF}));
        model_mem[10'h010] = merge(model_mem[10'h010], 32'hDEAD_BEEF, 4'b0011);

        // Write with no byte enables is still a full transaction.
        advance();
        a.dm_req = 1'b1; a.dm_we = 1'b1; a.dm_be = 4'b0000;
        a.dm_addr = 10'h011; a.dm_wdata = 32'hFFFF_FFFF;
        sample();
        check("be0 gnt", 64'(a.dm_gnt), 64'h1);
        advance();
        a.dm_req = 1'b0;
        sample();
        check("be0 mem_we", 64'(a.mem_we), 64'h1);
        check("be0 mem_be", 64'(a.mem_be), 64'h0);
        advance();
        sample();
        check("be0 dm_rvalid", 64'(a.dm_rvalid), 64'h1);
        check("be0 mem word", 64'(mem_a[10'h011]), 64'(model_mem[10'h011]));

        // Both requesters held high: four data grants, then one fetch, repeating.
        advance();
        a.dm_we = 1'b0; a.dm_addr = 10'h020; a.if_addr = 10'h030;
        a.if_req = 1'b1; a.dm_req = 1'b1;
        ng = 0; pat = '0;
        for (int c = 0; c < 200 && ng < 10; c++) begin
            sample();
            check("both one gnt", 64'(a.if_gnt & a.dm_gnt), 64'h0);
            if (a.dm_gnt || a.if_gnt) begin
                pat[ng] = a.if_gnt;
                ng++;
            end
            advance();
        end
        check("both grant count", 64'(ng), 64'd10);
        check("both grant pattern", 64'(pat), 64'h210);
        a.if_req = 1'b0; a.dm_req = 1'b0;
        repeat (3) advance();

        // Back-to-back data reads: second grant lands on the first rvalid.
        a.dm_req = 1'b1; a.dm_we = 1'b0; a.dm_addr = 10'h030;
        sample();
        check("b2b T gnt", 64'(a.dm_gnt), 64'h1);
        advance();
        a.dm_addr = 10'h031;
        sample();
        check("b2b T+1 gnt", 64'(a.dm_gnt), 64'h0);
        check("b2b T+1 busy", 64'(a.busy), 64'h1);
        advance();
        sample();
        check("b2b T+2 rvalid", 64'(a.dm_rvalid), 64'h1);
        check("b2b T+2 gnt", 64'(a.dm_gnt), 64'h1);
        check("b2b T+2 rdata", 64'(a.dm_rdata), 64'(model_mem[10'h030]));
        advance();
        a.dm_req = 1'b0;
        advance();
        sample();
        check("b2b T+4 rvalid", 64'(a.dm_rvalid), 64'h1);
        check("b2b T+4 rdata", 64'(a.dm_rdata), 64'(model_mem[10'h031]));

        // Reset in the middle of a write access.
        advance();
        a.dm_req = 1'b1; a.dm_we = 1'b1; a.dm_be = 4'hF;
        a.dm_addr = 10'h040; a.dm_wdata = 32'h1234_5678;
        sample();
        check("rst T gnt", 64'(a.dm_gnt), 64'h1);
        advance();
        a.dm_req = 1'b0; a.dm_we = 1'b0;
        check("rst pre mem_we", 64'(a.mem_we), 64'h1);
        check("rst pre busy", 64'(a.busy), 64'h1);
        a.if_req = 1'b1; a.if_addr = 10'h020;
        rst = 1'b0;
        #1;
        check_zero("rst mid");
        advance();
        check_zero("rst held");
        a.if_req = 1'b0;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample();
            check("rst after if_rvalid", 64'(a.if_rvalid), 64'h0);
            check("rst after dm_rvalid", 64'(a.dm_rvalid), 64'h0);
            check("rst after busy", 64'(a.busy), 64'h0);
            advance();
        end
        check("rst no write", 64'(mem_a[10'h040]), 64'(model_mem[10'h040]));
        a.if_req = 1'b1; a.if_addr = 10'h020;
        sample();
        check("fresh gnt", 64'(a.if_gnt), 64'h1);
        advance();
        a.if_req = 1'b0;
        advance();
        sample();
        check("fresh rvalid", 64'(a.if_rvalid), 64'h1);
        check("fresh rdata", 64'(a.if_rdata), 64'(model_mem[10'h020]));
        advance();

        // Randomized traffic against a transaction-level model of grant, timing and data.
        exp_if = model_mem[10'h020]; exp_dm = 32'h0;
        busy_left = 0; pend_v = 1'b0; wait_m = 0;
        pend_due = 0; pend_dm = 1'b0; pend_wr = 1'b0; pend_addr = '0;
        pend_be = '0; pend_data = '0; pend_wdata = '0;
        for (int c = 0; c < 600; c++) begin
            sample();
            idle_m = (busy_left == 0);
            e_dm   = idle_m && a.dm_req && !(a.if_req && wait_m == MAXW);
            e_if   = idle_m && a.if_req && !e_dm;
            e_ifv  = pend_v && pend_due == c && !pend_dm;
            e_dmv  = pend_v && pend_due == c && pend_dm;
            if (e_ifv) exp_if = pend_data;
            if (e_dmv && !pend_wr) exp_dm = pend_data;
            check("rnd if_gnt", 64'(a.if_gnt), 64'(e_if));
            check("rnd dm_gnt", 64'(a.dm_gnt), 64'(e_dm));
            check("rnd busy", 64'(a.busy), 64'(!idle_m));
            check("rnd if_rvalid", 64'(a.if_rvalid), 64'(e_ifv));
            check("rnd dm_rvalid", 64'(a.dm_rvalid), 64'(e_dmv));
            check("rnd if_rdata", 64'(a.if_rdata), 64'(exp_if));
            check("rnd dm_rdata", 64'(a.dm_rdata), 64'(exp_dm));
            check("rnd mem_we", 64'(a.mem_we), 64'(pend_v && pend_wr && c == pend_due - LAT_A));
            if (!idle_m) begin
                check("rnd mem_addr", 64'(a.mem_addr), 64'(pend_addr));
                check("rnd mem_be", 64'(a.mem_be), 64'(pend_be));
                if (pend_wr) check("rnd mem_wdata", 64'(a.mem_wdata), 64'(pend_wdata));
            end
            if (e_ifv || e_dmv) pend_v = 1'b0;
            if (e_if || e_dm) begin
                pend_v     = 1'b1;
                pend_due   = c + LAT_A + 1;
                pend_dm    = e_dm;
                pend_addr  = e_dm ? a.dm_addr : a.if_addr;
                pend_wr    = e_dm && a.dm_we;
                pend_be    = pend_wr ? a.dm_be : 4'h0;
                pend_wdata = a.dm_wdata;
                pend_data  = model_mem[pend_addr];
                if (pend_wr) model_mem[pend_addr] = merge(pend_data, a.dm_wdata, a.dm_be);
                busy_left  = LAT_A;
            end else if (busy_left > 0) begin
                busy_left--;
            end
            if (!a.if_req || e_if) wait_m = 0;
            else if (e_dm && wait_m < MAXW) wait_m++;
            g_if = a.if_gnt;
            g_dm = a.dm_gnt;
            advance();
            if (g_if || !a.if_req) begin
                a.if_req  = ($urandom_range(0, 99) < 60);
                a.if_addr = 10'($urandom_range(0, 15));
            end else if ($urandom_range(0, 99) < 2) begin
                a.if_req = 1'b0;
            end
            if (g_dm || !a.dm_req) begin
                a.dm_req   = ($urandom_range(0, 99) < 60);
                a.dm_we    = 1'($urandom_range(0, 1));
                a.dm_be    = 4'($urandom_range(0, 15));
                a.dm_addr  = 10'($urandom_range(0, 15));
                a.dm_wdata = $urandom;
            end else if ($urandom_range(0, 99) < 2) begin
                a.dm_req = 1'b0;
            end
        end
        a.if_req = 1'b0; a.dm_req = 1'b0;

        // LAT = 3: three busy cycles, no grant while busy, rvalid four cycles after grant.
        b.if_req = 1'b1; b.if_addr = 10'h007;
        sample();
        check("lat3 if gnt", 64'(b.if_gnt), 64'h1);
        advance();
        b.if_req = 1'b0; b.dm_req = 1'b1; b.dm_we = 1'b0; b.dm_addr = 10'h009;
        for (int k = 0; k < LAT_B; k++) begin
            sample();
            check("lat3 busy", 64'(b.busy), 64'h1);
            check("lat3 no gnt", 64'(b.dm_gnt | b.if_gnt), 64'h0);
            check("lat3 no rvalid", 64'(b.if_rvalid), 64'h0);
            check("lat3 mem_addr", 64'(b.mem_addr), 64'h007);
            advance();
        end
        sample();
        check("lat3 busy done", 64'(b.busy), 64'h0);
        check("lat3 if_rvalid", 64'(b.if_rvalid), 64'h1);
        check("lat3 if_rdata", 64'(b.if_rdata), 64'hB000_0007);
        check("lat3 dm gnt", 64'(b.dm_gnt), 64'h1);
        advance();
        b.dm_req = 1'b0;
        repeat (LAT_B) advance();
        sample();
        check("lat3 dm_rvalid", 64'(b.dm_rvalid), 64'h1);
        check("lat3 dm_rdata", 64'(b.dm_rdata), 64'hB000_0009);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
